// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns byte/half/word load and store requests into
// aligned big-endian word accesses, with read-modify-write for sub-word stores.
//
// Ports:
//   clk, reset_n         rising-edge clock, async active-low reset
//   req_valid            EX/MEM holds a memory instruction
//   MemRead, MemWrite    load / store request
//   MemDataSize          00 byte, 01 half, 10 word, 11 illegal
//   MemDataSign          sign-extend loads when 1
//   address, write_data  byte address, right-justified store data
//   stall                hold the upstream pipeline
//   resp_valid, err      access complete / request was rejected
//   read_data            formatted load result, held between responses
//   mem_*                word-wide data memory port
module mem_access_ctrl #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemDataSize,
    input  logic        MemDataSign,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] read_data,
    output logic        err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RMW_RD  = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(READ_LAT - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Big-endian lanes: byte offset 0 lives in bits [31:24], so the
    // right-shift distance for a byte is (3 - off) * 8 = {~off, 3'b000}.
    function automatic logic [31:0] fmt_load(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic [1:0]  off,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(w >> {~off, 3'b000});
        h = off[1] ? w[15:0] : w[31:16];
        unique case (sz)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_st(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic [1:0]  off,
        input logic [31:0] d
    );
        logic [4:0]  sh;
        logic [31:0] m;
        if (sz == SZ_BYTE) begin
            sh = {~off, 3'b000};
            m  = 32'h0000_00FF;
        end else begin
            sh = off[1] ? 5'd0 : 5'd16;
            m  = 32'h0000_FFFF;
        end
        return (w & ~(m << sh)) | ((d & m) << sh);
    endfunction

    state_e      state_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [1:0]  off_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wword_q;
    logic [31:0] rdata_q;
    logic [3:0]  cnt_q;
    logic        rd_q;
    logic        wr_q;
    logic        resp_q;
    logic        err_q;
    logic        stall_q;

    logic req_op;
    logic accept;
    logic bad_req;
    logic ld_go;
    logic sw_go;
    logic sub_go;

    assign req_op = req_valid & (MemRead | MemWrite);
    assign accept = reset_n & req_op & (state_q == IDLE);

    always_comb begin
        bad_req = 1'b0;
        if (MemRead & MemWrite) begin
            bad_req = 1'b1;
        end
        if (MemDataSize == SZ_ILL) begin
            bad_req = 1'b1;
        end
        if ((MemDataSize == SZ_HALF) && address[0]) begin
            bad_req = 1'b1;
        end
        if ((MemDataSize == SZ_WORD) && (address[1:0] != 2'b00)) begin
            bad_req = 1'b1;
        end
    end

    // Mutually exclusive request classes; exactly one holds on accept.
    assign ld_go  = ~bad_req & MemRead;
    assign sw_go  = ~bad_req & MemWrite & (MemDataSize == SZ_WORD);
    assign sub_go = ~bad_req & MemWrite & (MemDataSize != SZ_WORD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            size_q  <= '0;
            sign_q  <= 1'b0;
            off_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wword_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        size_q  <= MemDataSize;
                        sign_q  <= MemDataSign;
                        off_q   <= address[1:0];
                        addr_q  <= address[31:2];
                        wdata_q <= write_data;
                        cnt_q   <= CNT_INIT;
                        unique case (1'b1)
                            bad_req: begin
                                state_q <= DONE;
                                resp_q  <= 1'b1;
                                err_q   <= 1'b1;
                                rdata_q <= '0;
                            end
                            ld_go: begin
                                state_q <= RD_WAIT;
                                rd_q    <= 1'b1;
                                stall_q <= 1'b1;
                            end
                            sw_go: begin
                                state_q <= WR;
                                wword_q <= write_data;
                                wr_q    <= 1'b1;
                                stall_q <= 1'b1;
                            end
                            sub_go: begin
                                state_q <= RMW_RD;
                                rd_q    <= 1'b1;
                                stall_q <= 1'b1;
                            end
                        endcase
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                        rd_q    <= 1'b0;
                        stall_q <= 1'b0;
                        resp_q  <= 1'b1;
                        rdata_q <= fmt_load(mem_read_data, size_q,
                                            off_q, sign_q);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RMW_RD: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= WR;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b1;
                        wword_q <= merge_st(mem_read_data, size_q,
                                            off_q, wdata_q);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR: begin
                    state_q <= DONE;
                    wr_q    <= 1'b0;
                    stall_q <= 1'b0;
                    resp_q  <= 1'b1;
                    rdata_q <= '0;
                end
                DONE: begin
                    // req_valid is deliberately ignored here so the
                    // completing instruction is not accepted twice.
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall          = stall_q | accept;
    assign resp_valid     = resp_q;
    assign err            = err_q;
    assign read_data      = rdata_q;
    assign mem_address    = {addr_q, 2'b00};
    assign mem_write_data = wword_q;
    assign mem_MemRead    = rd_q;
    assign mem_MemWrite   = wr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vectors on READ_LAT=1, hand-written
// reset/hold/latency sequences, and random traffic on READ_LAT=1 and 3.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n        [2];
    logic        req_valid      [2];
    logic        MemRead        [2];
    logic        MemWrite       [2];
    logic [1:0]  MemDataSize    [2];
    logic        MemDataSign    [2];
    logic [31:0] address        [2];
    logic [31:0] write_data     [2];
    logic        stall          [2];
    logic        resp_valid     [2];
    logic [31:0] read_data      [2];
    logic        err            [2];
    logic [31:0] mem_address    [2];
    logic [31:0] mem_write_data [2];
    logic        mem_MemRead    [2];
    logic        mem_MemWrite   [2];
    logic [31:0] mem_read_data  [2];

    logic [31:0] mem    [2][64];
    logic [31:0] refmem [2][64];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_access_ctrl #(.READ_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk            (clk),
            .reset_n        (reset_n[g]),
            .req_valid      (req_valid[g]),
            .MemRead        (MemRead[g]),
            .MemWrite       (MemWrite[g]),
            .MemDataSize    (MemDataSize[g]),
            .MemDataSign    (MemDataSign[g]),
            .address        (address[g]),
            .write_data     (write_data[g]),
            .stall          (stall[g]),
            .resp_valid     (resp_valid[g]),
            .read_data      (read_data[g]),
            .err            (err[g]),
            .mem_address    (mem_address[g]),
            .mem_write_data (mem_write_data[g]),
            .mem_MemRead    (mem_MemRead[g]),
            .mem_MemWrite   (mem_MemWrite[g]),
            .mem_read_data  (mem_read_data[g])
        );
        assign mem_read_data[g] = mem[g][mem_address[g][7:2]];
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_MemWrite[g]) begin
                mem[g][mem_address[g][7:2]] <= mem_write_data[g];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    logic        o_err;
    logic [31:0] o_rdata;
    int          o_stall;
    int          o_nrd;
    int          o_nwr;
    int          o_bad;
    bit          o_got;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_st;
        int          e_nrd;
        int          e_nwr;
    } vec_t;

    vec_t tv [18];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] outs_or(input int d);
        return read_data[d] | mem_address[d] | mem_write_data[d] |
               {27'b0, stall[d], resp_valid[d], err[d],
                mem_MemRead[d], mem_MemWrite[d]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: memory as an array of big-endian byte lanes, results
    // built from plain arithmetic on byte positions.
    task automatic model(
        input  int          d,
        input  logic        rd,
        input  logic        wr,
        input  logic [1:0]  sz,
        input  logic        sg,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        output logic        e_err,
        output logic [31:0] e_rd,
        output int          e_st,
        output int          e_nrd,
        output int          e_nwr
    );
        int          wi;
        int          off;
        int          nb;
        int          v;
        int          L;
        logic [31:0] word;
        logic [31:0] nw;
        wi    = int'(a[7:2]);
        off   = int'(a[1:0]);
        L     = lat_of(d);
        word  = refmem[d][wi];
        e_err = (rd && wr) || (sz == 3) ||
                (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
        e_rd  = 0;
        e_st  = 1;
        e_nrd = 0;
        e_nwr = 0;
        if (!e_err && rd) begin
            e_st  = L + 1;
            e_nrd = L;
            if (sz == 0) begin
                v = int'((word >> (8 * (3 - off))) % 256);
                if (sg && v >= 128) v = v - 256;
                e_rd = 32'(v);
            end else if (sz == 1) begin
                v = int'((word >> (8 * (2 - off))) % 65536);
                if (sg && v >= 32768) v = v - 65536;
                e_rd = 32'(v);
            end else begin
                e_rd = word;
            end
        end else if (!e_err) begin
            e_nwr = 1;
            if (sz == 2) begin
                e_st = 2;
                refmem[d][wi] = wd;
            end else begin
                e_st  = L + 2;
                e_nrd = L;
                nb    = (sz == 0) ? 1 : 2;
                nw    = 0;
                for (int k = 0; k < 4; k++) begin
                    if (k >= off && k < off + nb)
                        v = int'((wd >> (8 * (nb - 1 - (k - off)))) % 256);
                    else
                        v = int'((word >> (8 * (3 - k))) % 256);
                    nw = nw * 256 + 32'(v);
                end
                refmem[d][wi] = nw;
            end
        end
    endtask

    task automatic run(
        input int          d,
        input logic        rd,
        input logic        wr,
        input logic [1:0]  sz,
        input logic        sg,
        input logic [31:0] a,
        input logic [31:0] wd
    );
        @(negedge clk);
        req_valid[d]   = 1'b1;
        MemRead[d]     = rd;
        MemWrite[d]    = wr;
        MemDataSize[d] = sz;
        MemDataSign[d] = sg;
        address[d]     = a;
        write_data[d]  = wd;
        o_err   = 1'b0;
        o_rdata = 32'h0;
        o_stall = 0;
        o_nrd   = 0;
        o_nwr   = 0;
        o_bad   = 0;
        o_got   = 1'b0;
        for (int c = 0; c < 40 && !o_got; c++) begin
            #1;
            if (stall[d]) o_stall++;
            if (mem_MemRead[d]) begin
                o_nrd++;
                if (mem_address[d] != {a[31:2], 2'b00}) o_bad++;
            end
            if (mem_MemWrite[d]) begin
                o_nwr++;
                if (mem_address[d] != {a[31:2], 2'b00}) o_bad++;
            end
            if (mem_MemRead[d] && mem_MemWrite[d]) o_bad++;
            if (resp_valid[d]) begin
                o_got   = 1'b1;
                o_err   = err[d];
                o_rdata = read_data[d];
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic compare(input string nm, input logic e_err,
                           input logic [31:0] e_rd, input int e_st,
                           input int e_nrd, input int e_nwr);
        chk({nm, "_resp"}, 32'(o_got), 32'd1);
        chk({nm, "_err"}, 32'(o_err), 32'(e_err));
        chk({nm, "_rdata"}, o_rdata, e_rd);
        chk({nm, "_stall"}, 32'(o_stall), 32'(e_st));
        chk({nm, "_nrd"}, 32'(o_nrd), 32'(e_nrd));
        chk({nm, "_nwr"}, 32'(o_nwr), 32'(e_nwr));
        chk({nm, "_addr"}, 32'(o_bad), 32'd0);
    endtask

    task automatic idle(input int d, input bit nop, input string nm);
        @(negedge clk);
        req_valid[d] = nop;
        MemRead[d]   = 1'b0;
        MemWrite[d]  = 1'b0;
        address[d]   = $urandom;
        #1;
        chk(nm, {28'b0, stall[d], resp_valid[d],
                 mem_MemRead[d], mem_MemWrite[d]}, 32'd0);
    endtask

    task automatic rand_txn(input int d, input int n);
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_st;
        int          e_nrd;
        int          e_nwr;
        int          r;
        r  = int'($urandom_range(0, 19));
        rd = (r == 0) || (r < 10);
        wr = (r == 0) || (r >= 10);
        r  = int'($urandom_range(0, 9));
        sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        a  = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            if (sz == 1) a[0] = 1'b0;
            if (sz == 2) a[1:0] = 2'b00;
        end
        sg = 1'($urandom);
        wd = $urandom;
        model(d, rd, wr, sz, sg, a, wd, e_err, e_rd, e_st, e_nrd, e_nwr);
        run(d, rd, wr, sz, sg, a, wd);
        compare($sformatf("rnd%0d_%0d", d, n), e_err, e_rd, e_st,
                e_nrd, e_nwr);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e_err;
        logic [31:0] e_rd;
        logic [31:0] held;
        int          e_st;
        int          e_nrd;
        int          e_nwr;

        for (int d = 0; d < 2; d++) begin
            reset_n[d]     = 1'b1;
            req_valid[d]   = 1'b1;
            MemRead[d]     = 1'b1;
            MemWrite[d]    = 1'b0;
            MemDataSize[d] = 2'd2;
            MemDataSign[d] = 1'b0;
            address[d]     = 32'h10;
            write_data[d]  = 32'h0;
            for (int i = 0; i < 64; i++) begin
                refmem[d][i] = (i == 4) ? 32'h80A1B2C3 :
                               32'(i) * 32'h01010101 ^ 32'h5A3C_96E1;
                mem[d][i] <= refmem[d][i];
            end
        end

        #2;
        reset_n[0] = 1'b0;
        reset_n[1] = 1'b0;
        #1;
        chk("reset_outs0", outs_or(0), 32'd0);
        chk("reset_outs1", outs_or(1), 32'd0);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;

        tv[0]  = '{1, 0, 0, 1, 32'h11, 0, 0, 32'hFFFFFFA1, 2, 1, 0};
        tv[1]  = '{1, 0, 0, 0, 32'h11, 0, 0, 32'h000000A1, 2, 1, 0};
        tv[2]  = '{1, 0, 1, 1, 32'h10, 0, 0, 32'hFFFF80A1, 2, 1, 0};
        tv[3]  = '{1, 0, 1, 0, 32'h12, 0, 0, 32'h0000B2C3, 2, 1, 0};
        tv[4]  = '{1, 0, 2, 0, 32'h10, 0, 0, 32'h80A1B2C3, 2, 1, 0};
        tv[5]  = '{1, 0, 0, 1, 32'h10, 0, 0, 32'hFFFFFF80, 2, 1, 0};
        tv[6]  = '{0, 1, 0, 0, 32'h13, 32'h5A, 0, 0, 3, 1, 1};
        tv[7]  = '{1, 0, 2, 0, 32'h10, 0, 0, 32'h80A1B25A, 2, 1, 0};
        tv[8]  = '{0, 1, 2, 0, 32'h04, 32'h01234567, 0, 0, 2, 0, 1};
        tv[9]  = '{1, 0, 2, 0, 32'h04, 0, 0, 32'h01234567, 2, 1, 0};
        tv[10] = '{0, 1, 1, 0, 32'h12, 32'hBEEF, 0, 0, 3, 1, 1};
        tv[11] = '{1, 0, 2, 1, 32'h10, 0, 0, 32'h80A1BEEF, 2, 1, 0};
        tv[12] = '{1, 0, 2, 0, 32'h06, 0, 1, 0, 1, 0, 0};
        tv[13] = '{0, 1, 1, 0, 32'h13, 32'h1234, 1, 0, 1, 0, 0};
        tv[14] = '{1, 0, 3, 0, 32'h10, 0, 1, 0, 1, 0, 0};
        tv[15] = '{1, 1, 2, 0, 32'h10, 32'h55, 1, 0, 1, 0, 0};
        tv[16] = '{1, 0, 1, 1, 32'h12, 0, 0, 32'hFFFFBEEF, 2, 1, 0};
        tv[17] = '{1, 0, 0, 0, 32'h12, 0, 0, 32'h000000BE, 2, 1, 0};

        for (int i = 0; i < 18; i++) begin
            model(0, tv[i].rd, tv[i].wr, tv[i].sz, tv[i].sg, tv[i].a,
                  tv[i].wd, e_err, e_rd, e_st, e_nrd, e_nwr);
            run(0, tv[i].rd, tv[i].wr, tv[i].sz, tv[i].sg, tv[i].a,
                tv[i].wd);
            compare($sformatf("vec%0d", i), tv[i].e_err, tv[i].e_rd,
                    tv[i].e_st, tv[i].e_nrd, tv[i].e_nwr);
        end

        idle(0, 1'b0, "idle_noreq");
        idle(0, 1'b1, "idle_nop");

        run(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        held = o_rdata;
        chk("hold_first", held, 32'h80A1BEEF);
        idle(0, 1'b0, "hold_idle");
        chk("hold_rdata", read_data[0], 32'h80A1BEEF);
        idle(0, 1'b0, "hold_idle2");
        chk("hold_rdata2", read_data[0], 32'h80A1BEEF);

        @(negedge clk);
        req_valid[0]   = 1'b1;
        MemRead[0]     = 1'b0;
        MemWrite[0]    = 1'b1;
        MemDataSize[0] = 2'd0;
        MemDataSign[0] = 1'b0;
        address[0]     = 32'h11;
        write_data[0]  = 32'h77;
        @(negedge clk);
        #1;
        chk("rst_inflight_rd", 32'(mem_MemRead[0]), 32'd1);
        reset_n[0] = 1'b0;
        #1;
        chk("rst_mid_outs", outs_or(0), 32'd0);
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_outs_hold", outs_or(0), 32'd0);
        chk("rst_mem_kept", mem[0][4], refmem[0][4]);
        reset_n[0] = 1'b1;
        model(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0,
              e_err, e_rd, e_st, e_nrd, e_nwr);
        run(0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        compare("after_rst", e_err, e_rd, e_st, e_nrd, e_nwr);
        chk("after_rst_val", o_rdata, 32'h000000A1);
        idle(0, 1'b0, "after_rst_idle");

        run(1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        chk("lat3_lb_stall", 32'(o_stall), 32'd4);
        chk("lat3_lb_nrd", 32'(o_nrd), 32'd3);
        chk("lat3_lb_rdata", o_rdata, 32'hFFFFFFA1);
        run(1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h5A);
        chk("lat3_sb_stall", 32'(o_stall), 32'd5);
        chk("lat3_sb_nwr", 32'(o_nwr), 32'd1);
        refmem[1][4] = 32'h80A1B25A;
        idle(1, 1'b0, "lat3_idle");

        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                if ($urandom_range(0, 9) == 0)
                    idle(d, 1'($urandom), $sformatf("rnd_idle%0d_%0d", d, n));
                else
                    rand_txn(d, n);
            end
            idle(d, 1'b0, "rnd_end_idle");
        end

        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) begin
                chk($sformatf("mem%0d_w%0d", d, i), mem[d][i], refmem[d][i]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
